// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 width codes,
// default MMIO addresses, and byte-lane / alignment helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [9:0] MMIO_TX_ADDR_DEF  = 10'h3FC;
  localparam logic [9:0] MMIO_CNT_ADDR_DEF = 10'h3F8;

  // Unlisted funct3 codes are treated as word accesses.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] sd;
    case (f3)
      F3_B, F3_BU: sd = {4{wd[7:0]}};
      F3_H, F3_HU: sd = {2{wd[15:0]}};
      default:     sd = wd;
    endcase
    return sd;
  endfunction

endpackage

// File: rtl/dbg_tx_fifo.sv
// Count-tracked synchronous FIFO for the debug byte stream; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module dbg_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I data-memory controller: byte-lane RAM, misalignment flagging and a
// memory-mapped debug TX FIFO; DMEM_CYCLE_COUNTER_EN adds an MMIO cycle counter.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int                ADDR_W        = 10,
  parameter int                FIFO_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] MMIO_TX_ADDR  = MMIO_TX_ADDR_DEF,
  parameter logic [ADDR_W-1:0] MMIO_CNT_ADDR = MMIO_CNT_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        funct3,
  input  logic              write_en,
  input  logic              read_en,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic [7:0]        dbg_data,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic              dbg_overflow
);

  localparam int WORDS = 2**(ADDR_W-2);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        off;
  logic [ADDR_W-3:0] widx;
  logic [3:0]        be;
  logic [31:0]       st_data;
  logic              mis, is_tx, is_cnt;
  logic [31:0]       ram_word, cnt_word, rd_sel;
  logic              ram_we, tx_push, tx_pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     unused_fifo_count;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              ovf_q, ovf_d;

  assign off     = addr[1:0];
  assign widx    = addr[ADDR_W-1:2];
  assign be      = byte_en(funct3, off);
  assign st_data = store_data(funct3, wdata);
  assign mis     = misaligned(funct3, off);
  assign is_tx   = (widx == MMIO_TX_ADDR[ADDR_W-1:2]);

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cnt_q, cnt_d;

  assign is_cnt = (widx == MMIO_CNT_ADDR[ADDR_W-1:2]);

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (write_en && !mis && is_cnt && (funct3 == F3_W)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_word = cnt_q;
`else
  logic [ADDR_W-1:0] unused_cnt_addr;
  assign unused_cnt_addr = MMIO_CNT_ADDR;
  assign is_cnt   = 1'b0;
  assign cnt_word = '0;
`endif

  // MMIO words are carved out of the RAM: stores there never touch the array.
  assign ram_we = write_en && !mis && !is_tx && !is_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      always_ff @(posedge clk) begin
        if (ram_we && be[gi]) lane_mem[widx] <= st_data[8*gi +: 8];
      end
      assign ram_word[8*gi +: 8] = lane_mem[widx];
    end
  endgenerate

  always_comb begin
    rd_sel = ram_word;
    if (is_tx)       rd_sel = {29'b0, ovf_q, fifo_full, fifo_empty};
    else if (is_cnt) rd_sel = cnt_word;
    // rd_sel is the pre-edge word, which gives read-first on a same-word store.
    rdata_d = rdata_q;
    if (read_en) rdata_d = mis ? 32'd0 : (rd_sel >> {off, 3'b000});
    misalign_d = (read_en || write_en) && mis;
    tx_push    = write_en && !mis && is_tx;
    tx_pop     = !fifo_empty && dbg_ready;
    ovf_d      = ovf_q || (tx_push && fifo_full && !tx_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      ovf_q      <= ovf_d;
    end
  end

  dbg_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata[7:0]),
    .dout  (dbg_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  assign rdata        = rdata_q;
  assign misalign     = misalign_q;
  assign dbg_valid    = !fifo_empty;
  assign dbg_overflow = ovf_q;

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory controller downstream of the RV32I core's execute/memory boundary. It consumes the core's data port (byte address, store data, write strobe, funct3) and returns load data to the writeback stage one cycle later. It contains the word-organised data RAM with byte-lane writes and misalignment detection. The top RAM words are memory-mapped registers: a debug byte-output FIFO and, optionally, a cycle counter.

Parameters:
ADDR_W, 10, byte-address width; RAM holds 2**(ADDR_W-2) words.
FIFO_DEPTH, 4, debug TX FIFO entries (power of two, >=2).
MMIO_TX_ADDR, 10'h3FC, byte address of the debug TX register (word-aligned).
MMIO_CNT_ADDR, 10'h3F8, byte address of the cycle counter (used only when the optional feature is compiled in).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_W  byte address from the memory stage (the ALU result)
wdata  in  32  store data, unshifted rs2 value
funct3  in  3  load/store width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
write_en  in  1  store request this cycle
read_en  in  1  load request this cycle
rdata  out  32  load data, right-justified by byte offset; the writeback stage performs sign/zero extension
misalign  out  1  one-cycle pulse, registered, flags a misaligned access
dbg_data  out  8  head byte of the TX FIFO
dbg_valid  out  1  FIFO not empty
dbg_ready  in  1  consumer accepts dbg_data when dbg_valid is high
dbg_overflow  out  1  sticky; set when a push is dropped because the FIFO is full

Behaviour:
- Reset, asynchronous active-low: rdata=0, misalign=0, FIFO pointers and count=0, dbg_valid=0, dbg_overflow=0, cycle counter=0. RAM contents are not reset.
- Byte offset: off=addr[1:0]. Word index: addr[ADDR_W-1:2].
- Alignment: halfword requires off[0]=0; word requires off=0; byte is always aligned.
- Misaligned access (read or write): no RAM or MMIO side effect. misalign=1 on the next cycle. rdata=0 for a misaligned load.
- Store byte enables:
  - B: 4'b0001<<off
  - H: 4'b0011<<off
  - W: 4'b1111
  - Store data is lane-replicated: B -> {4{wdata[7:0]}}, H -> {2{wdata[15:0]}}.
- Load latency is 1 cycle: rdata is registered on the edge after read_en and holds until the next valid load.
- rdata = stored_word >> (8*off). Upper bits are don't-care beyond the access width but are driven deterministically by the shift.
- Read and write to the same word in one cycle: read-first; rdata returns the old word.
- write_en and read_en both high to different addresses: both are performed.
- Writes to MMIO_TX_ADDR:
  - Any aligned store width pushes wdata[7:0].
  - If the FIFO is full and no pop happens this cycle, the byte is dropped and dbg_overflow is set.
  - If full and popping in the same cycle, the push is accepted.
- Reads of MMIO_TX_ADDR return {29'b0, dbg_overflow, full, empty}.
- MMIO words never alias RAM; a store there does not modify the RAM array.
- Pop occurs when dbg_valid && dbg_ready. dbg_data is the registered head byte, valid whenever dbg_valid=1.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked by a count, so full and empty are unambiguous.
- Reset asserted mid-transfer discards all FIFO contents immediately.

Optional Feature:
DMEM_CYCLE_COUNTER_EN
- Defined: a free-running 32-bit counter increments every clk after reset and wraps at 2^32. Loads from MMIO_CNT_ADDR return its value sampled in the request cycle. Stores to MMIO_CNT_ADDR clear it to 0 if the store is a word store, and are ignored otherwise.
- Undefined: MMIO_CNT_ADDR is ordinary RAM and no counter is synthesised.

Decomposition:
- Package dmem_pkg holds:
  - funct3 width localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the MMIO address defaults
  - a function returning byte enables from funct3 and offset
  - a function returning the misaligned flag
- Sub-module dbg_tx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by FIFO_DEPTH and WIDTH=8, with the same async active-low reset.

Test Plan:
- SW 0x11223344 @0x010, then LW @0x010 -> rdata=0x11223344 one cycle after read_en; misalign stays 0.
- SB 0xAA @0x013, then LW @0x010 -> 0xAA223344. LBU @0x013 -> rdata[7:0]=0xAA.
- SH @0x011 -> misalign pulses for exactly 1 cycle and RAM @0x010 is unchanged. LW @0x012 -> misalign=1 and rdata=0.
- Five SB to 0x3FC (bytes 1..5) with dbg_ready=0 -> FIFO holds 1..4 and dbg_overflow=1. Raise dbg_ready -> bytes 1,2,3,4 emerge in order, then dbg_valid=0.
- FIFO full, SB 0x55 to 0x3FC in the same cycle dbg_ready=1 -> push accepted and overflow stays 0. Assert rst_n=0 mid-drain -> dbg_valid=0 immediately (asynchronous).
- With DMEM_CYCLE_COUNTER_EN: SW 0 to 0x3F8, wait 10 cycles, LW 0x3F8 -> value 10±1 per the defined sampling point. Without the macro: SW 0xDEADBEEF @0x3F8, then LW -> 0xDEADBEEF.
